// File: rtl/iic_pkg.sv
// Shared definitions for the I2C initiator/target pair: FSM state encoding and R/W bit values.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } iic_state_e;

  localparam logic IIC_WRITE = 1'b0;
  localparam logic IIC_READ  = 1'b1;

endpackage

// File: rtl/iic_sync_edge.sv
// Multi-stage synchronizer for one bus line, with rise/fall strobes on the synchronized level.
module iic_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_prev;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '1;
      q_prev <= 1'b1;
    end else begin
      sync   <= {sync[STAGES-2:0], d};
      q_prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/iic_target.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, byte write delivery and read shifting.
//   state       | meaning
//   ST_IDLE     | waiting for START
//   ST_ADDR     | shifting in address + R/W
//   ST_ADDR_ACK | driving/releasing ACK for our address
//   ST_WR_DATA  | shifting in a written byte
//   ST_WR_ACK   | driving/releasing ACK for a written byte
//   ST_RD_DATA  | driving a read byte MSB-first
//   ST_RD_ACK   | sampling the initiator's ACK/NACK
module iic_target
  import iic_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy,
  output logic       underrun
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic bus_start, bus_stop;

  iic_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .d(scl_i), .q(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  iic_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .d(sda_i), .q(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  assign bus_start = scl_s & sda_fall;
  assign bus_stop  = scl_s & sda_rise;
  assign sda_o     = 1'b0;

  iic_state_e state, state_nx;
  logic [2:0] bitcnt, bitcnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       oen_nx, rw, rw_nx, ack_drv, ack_drv_nx, rd_done, rd_done_nx;
  logic [7:0] rx_data_nx;
  logic       rx_valid_nx, tx_ack_nx, underrun_nx, busy_nx;
  logic [7:0] tx_byte, shin;

  assign tx_byte = tx_valid ? tx_data : 8'hFF;
  assign shin    = {shreg[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bitcnt    <= 3'd7;
      shreg     <= 8'h00;
      sda_oen_n <= 1'b1;
      rw        <= IIC_WRITE;
      ack_drv   <= 1'b0;
      rd_done   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      bitcnt    <= bitcnt_nx;
      shreg     <= shreg_nx;
      sda_oen_n <= oen_nx;
      rw        <= rw_nx;
      ack_drv   <= ack_drv_nx;
      rd_done   <= rd_done_nx;
      rx_data   <= rx_data_nx;
      rx_valid  <= rx_valid_nx;
      tx_ack    <= tx_ack_nx;
      underrun  <= underrun_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bitcnt_nx   = bitcnt;
    shreg_nx    = shreg;
    oen_nx      = sda_oen_n;
    rw_nx       = rw;
    ack_drv_nx  = ack_drv;
    rd_done_nx  = rd_done;
    rx_data_nx  = rx_data;
    busy_nx     = busy;
    rx_valid_nx = 1'b0;
    tx_ack_nx   = 1'b0;
    underrun_nx = 1'b0;

    if (bus_start) begin
      state_nx   = ST_ADDR;
      bitcnt_nx  = 3'd7;
      oen_nx     = 1'b1;
      ack_drv_nx = 1'b0;
      busy_nx    = 1'b0;
    end else if (bus_stop) begin
      state_nx   = ST_IDLE;
      oen_nx     = 1'b1;
      ack_drv_nx = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shreg_nx = shin;
          if (bitcnt == 3'd0) begin
            if (shin[7:1] == ADDR) begin
              state_nx   = ST_ADDR_ACK;
              rw_nx      = shin[0];
              ack_drv_nx = 1'b0;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            bitcnt_nx = bitcnt - 3'd1;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!ack_drv) begin
            oen_nx     = 1'b0;
            ack_drv_nx = 1'b1;
            if (state == ST_ADDR_ACK) busy_nx = 1'b1;
          end else begin
            ack_drv_nx = 1'b0;
            oen_nx     = 1'b1;
            bitcnt_nx  = 3'd7;
            state_nx   = ST_WR_DATA;
            // The release fall is also the first read bit's launch edge, so bit 7 goes out here.
            if (state == ST_ADDR_ACK && rw == IIC_READ) begin
              state_nx    = ST_RD_DATA;
              oen_nx      = tx_byte[7];
              shreg_nx    = {tx_byte[6:0], 1'b1};
              bitcnt_nx   = 3'd6;
              rd_done_nx  = 1'b0;
              tx_ack_nx   = tx_valid;
              underrun_nx = ~tx_valid;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shreg_nx = shin;
          if (bitcnt == 3'd0) begin
            rx_data_nx  = shin;
            rx_valid_nx = 1'b1;
            ack_drv_nx  = 1'b0;
            state_nx    = ST_WR_ACK;
          end else begin
            bitcnt_nx = bitcnt - 3'd1;
          end
        end
        ST_RD_DATA: if (scl_fall) begin
          if (rd_done) begin
            oen_nx   = 1'b1;
            state_nx = ST_RD_ACK;
          end else begin
            oen_nx   = shreg[7];
            shreg_nx = {shreg[6:0], 1'b1};
            if (bitcnt == 3'd0) rd_done_nx = 1'b1;
            else                bitcnt_nx  = bitcnt - 3'd1;
          end
        end
        ST_RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            state_nx    = ST_RD_DATA;
            shreg_nx    = tx_byte;
            bitcnt_nx   = 3'd7;
            rd_done_nx  = 1'b0;
            tx_ack_nx   = tx_valid;
            underrun_nx = ~tx_valid;
          end else begin
            state_nx = ST_IDLE;
            busy_nx  = 1'b0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule
